// File: rtl/mips_mem_system.sv
// Memory and I/O subsystem behind the 8-bit multicycle MIPS core: byte RAM,
// transmit FIFO, GPIO and free-running timer, all with 1-cycle registered reads.
module mips_mem_system #(
  parameter int unsigned            WIDTH      = 8,
  parameter int unsigned            RAM_DEPTH  = 240,
  parameter logic [WIDTH-1:0]       IO_BASE    = 8'hF0,
  parameter int unsigned            FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             memread,
  input  logic             memwrite,
  output logic [WIDTH-1:0] memdata,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [WIDTH-1:0] OFF_TXDATA   = WIDTH'(0);
  localparam logic [WIDTH-1:0] OFF_STATUS   = WIDTH'(1);
  localparam logic [WIDTH-1:0] OFF_GPIO_OUT = WIDTH'(2);
  localparam logic [WIDTH-1:0] OFF_GPIO_IN  = WIDTH'(3);
  localparam logic [WIDTH-1:0] OFF_TIMER    = WIDTH'(4);

  logic [WIDTH-1:0] ram      [RAM_DEPTH];
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [WIDTH-1:0] timer;
  logic [WIDTH-1:0] gpio_sync1;
  logic [WIDTH-1:0] gpio_sync2;

  logic             is_ram_c;
  logic [WIDTH-1:0] io_off_c;
  logic             empty_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             accept_c;
  logic             ovf_set_c;
  logic             ovf_clr_c;
  logic             wr_gpio_c;
  logic             wr_timer_c;
  logic [WIDTH-1:0] rd_val_c;

  // Address decode and FIFO handshake
  always_comb begin
    is_ram_c   = (adr < WIDTH'(RAM_DEPTH));
    io_off_c   = adr - IO_BASE;
    empty_c    = (count == '0);
    full_c     = (count == CNT_W'(FIFO_DEPTH));
    pop_c      = !empty_c && tx_ready;
    push_c     = memwrite && !is_ram_c && (io_off_c == OFF_TXDATA);
    // A full FIFO still takes a push when the head leaves on the same edge
    accept_c   = push_c && (!full_c || pop_c);
    ovf_set_c  = push_c && full_c && !pop_c;
    ovf_clr_c  = memwrite && !is_ram_c && (io_off_c == OFF_STATUS) && writedata[2];
    wr_gpio_c  = memwrite && !is_ram_c && (io_off_c == OFF_GPIO_OUT);
    wr_timer_c = memwrite && !is_ram_c && (io_off_c == OFF_TIMER);
  end

  // Read mux over pre-edge state
  always_comb begin
    rd_val_c = '0;
    if (is_ram_c) begin
      rd_val_c = ram[adr];
    end else begin
      case (io_off_c)
        OFF_STATUS:   rd_val_c = WIDTH'({overflow, full_c, empty_c});
        OFF_GPIO_OUT: rd_val_c = gpio_out;
        OFF_GPIO_IN:  rd_val_c = gpio_sync2;
        OFF_TIMER:    rd_val_c = timer;
        default:      rd_val_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memdata    <= '0;
      gpio_out   <= '0;
      timer      <= '0;
      overflow   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      if (memread) begin
        memdata <= rd_val_c;
      end
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (wr_timer_c) begin
        timer <= writedata;
      end else begin
        timer <= timer + WIDTH'(1);
      end
      if (wr_gpio_c) begin
        gpio_out <= writedata;
      end
      if (ovf_set_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr_c) begin
        overflow <= 1'b0;
      end
      if (accept_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(accept_c) - CNT_W'(pop_c);
    end
  end

  // Storage arrays carry no reset
  always_ff @(posedge clk) begin
    if (!rst && accept_c) begin
      fifo_mem[wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && memwrite && is_ram_c) begin
      ram[adr] <= writedata;
    end
  end

  assign tx_valid = !empty_c;
  assign tx_data  = empty_c ? '0 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_mips_mem_system.sv
// Directed plus randomized bench for mips_mem_system against a queue-based
// behavioural model of the memory map.
module tb_mips_mem_system;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] memdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;

  always #5 clk = ~clk;

  mips_mem_system dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .writedata (writedata),
    .memread   (memread),
    .memwrite  (memwrite),
    .memdata   (memdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0] ram_m [256];
  logic [7:0] q_m [$];
  logic       ovf_m;
  logic [7:0] timer_m;
  logic [7:0] gpio_out_m;
  logic [7:0] md_m;
  logic [7:0] hist_m [2];   // gpio_in seen one and two edges back

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a < 8'd240) return ram_m[a];
    case (a)
      8'hF1:   return {5'b0, ovf_m, (q_m.size() == 4), (q_m.size() == 0)};
      8'hF2:   return gpio_out_m;
      8'hF3:   return hist_m[1];
      8'hF4:   return timer_m;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: drive, advance model at the edge, compare 1 time unit later
  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] wd,
                      input logic rd, input logic wr, input logic rdy);
    logic [7:0] rv;
    logic       pop;
    rst = r; adr = a; writedata = wd; memread = rd; memwrite = wr; tx_ready = rdy;
    rv  = model_read(a);
    pop = (q_m.size() != 0) && rdy;
    @(posedge clk);
    if (r) begin
      md_m = 8'h00; q_m.delete(); ovf_m = 1'b0; timer_m = 8'h00;
      gpio_out_m = 8'h00; hist_m[0] = 8'h00; hist_m[1] = 8'h00;
    end else begin
      if (rd) md_m = rv;
      if (pop) void'(q_m.pop_front());
      if (wr && a == 8'hF0) begin
        if (q_m.size() < 4) q_m.push_back(wd);
        else ovf_m = 1'b1;
      end
      if (wr && a == 8'hF1 && wd[2]) ovf_m = 1'b0;
      if (wr && a == 8'hF2) gpio_out_m = wd;
      timer_m = (wr && a == 8'hF4) ? wd : timer_m + 8'd1;
      if (wr && a < 8'd240) ram_m[a] = wd;
      hist_m[1] = hist_m[0];
      hist_m[0] = gpio_in;
    end
    #1;
    chk("memdata",  memdata,        md_m);
    chk("tx_valid", 8'(tx_valid),   8'(q_m.size() != 0));
    chk("tx_data",  tx_data,        (q_m.size() != 0) ? q_m[0] : 8'h00);
    chk("gpio_out", gpio_out,       gpio_out_m);
  endtask

  task automatic do_rst();                                  step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_wr(input logic [7:0] a, input logic [7:0] d); step(1'b0, a, d, 1'b0, 1'b1, 1'b0); endtask
  task automatic do_rd(input logic [7:0] a);                step(1'b0, a, 8'h00, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_pop();                                  step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1); endtask
  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    gpio_in = 8'h00;
    md_m = 8'h00; ovf_m = 1'b0; timer_m = 8'h00; gpio_out_m = 8'h00;
    hist_m[0] = 8'h00; hist_m[1] = 8'h00;

    // Reset held two cycles, then RAM access
    do_rst(); do_rst();
    chk("rst_memdata", memdata, 8'h00);
    chk("rst_txvalid", 8'(tx_valid), 8'h00);
    for (int i = 0; i < 240; i++) do_wr(8'(i), 8'($urandom));
    do_wr(8'h10, 8'h5A);
    do_rd(8'h10);
    chk("ram_read", memdata, 8'h5A);
    step(1'b0, 8'h10, 8'hA5, 1'b1, 1'b1, 1'b0);
    chk("ram_rbw", memdata, 8'h5A);
    do_rd(8'h10);
    chk("ram_reread", memdata, 8'hA5);

    // FIFO fill, overflow, drain, clear
    do_wr(8'hF0, 8'h11); do_wr(8'hF0, 8'h22); do_wr(8'hF0, 8'h33); do_wr(8'hF0, 8'h44);
    do_rd(8'hF1);
    chk("status_full", memdata, 8'h02);
    chk("head_first", tx_data, 8'h11);
    do_wr(8'hF0, 8'h55);
    do_rd(8'hF1);
    chk("status_ovf", memdata, 8'h06);
    do_pop(); chk("drain_2", tx_data, 8'h22);
    do_pop(); chk("drain_3", tx_data, 8'h33);
    do_pop(); chk("drain_4", tx_data, 8'h44);
    do_pop(); chk("drained", 8'(tx_valid), 8'h00);
    do_rd(8'hF1);
    chk("status_empty_ovf", memdata, 8'h05);
    do_wr(8'hF1, 8'h04);
    do_rd(8'hF1);
    chk("status_cleared", memdata, 8'h01);

    // Push and pop on the same edge while full
    do_wr(8'hF0, 8'hA1); do_wr(8'hF0, 8'hA2); do_wr(8'hF0, 8'hA3); do_wr(8'hF0, 8'hA4);
    step(1'b0, 8'hF0, 8'h66, 1'b0, 1'b1, 1'b1);
    do_rd(8'hF1);
    chk("status_pushpop", memdata, 8'h02);
    do_pop(); do_pop(); do_pop();
    chk("last_byte", tx_data, 8'h66);
    do_pop();

    // Timer count, load and wrap
    do_rst();
    do_idle(9);
    do_rd(8'hF4);
    chk("timer_10th", memdata, 8'h09);
    do_wr(8'hF4, 8'hFE);
    do_idle(1);
    do_rd(8'hF4);
    chk("timer_load", memdata, 8'hFF);
    do_rd(8'hF4);
    chk("timer_wrap", memdata, 8'h00);

    // GPIO out, synchronized in, unmapped read
    do_wr(8'hF2, 8'hC3);
    chk("gpio_out_wr", gpio_out, 8'hC3);
    do_rd(8'hF2);
    chk("gpio_out_rd", memdata, 8'hC3);
    gpio_in = 8'h3C;
    do_idle(2);
    do_rd(8'hF3);
    chk("gpio_in_sync", memdata, 8'h3C);
    do_rd(8'hF7);
    chk("unmapped", memdata, 8'h00);

    // Reset in the middle of activity
    do_wr(8'hF0, 8'h01); do_wr(8'hF0, 8'h02); do_wr(8'hF0, 8'h03); do_wr(8'hF0, 8'h04);
    do_wr(8'hF0, 8'h05);
    do_pop();
    do_wr(8'hF4, 8'h80);
    step(1'b1, 8'hF4, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("midrst_memdata", memdata, 8'h00);
    chk("midrst_txvalid", 8'(tx_valid), 8'h00);
    chk("midrst_gpio", gpio_out, 8'h00);
    do_rd(8'hF1);
    chk("midrst_status", memdata, 8'h01);
    do_rd(8'hF4);
    chk("midrst_timer", memdata, 8'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      a = ($urandom_range(0, 1) == 0) ? 8'(8'hF0 + $urandom_range(0, 7)) : 8'($urandom);
      step(($urandom_range(0, 299) == 0), a, 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
